// File: rtl/pc_controller_if.sv
// Request/response bundle between the pipeline and pc_controller.
// `PC_CTRL_EXC_EN adds the exc request and epc result.
interface pc_controller_if;
  logic        stall;
  logic        halt;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] reg_target;
  logic [31:0] curAddress;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
`ifdef PC_CTRL_EXC_EN
  logic        exc;
  logic [31:0] epc;

  modport master (
    output stall, halt, branch_taken, branch_target, jump, jump_index, jr, reg_target, exc,
    input  curAddress, pc_plus4, fetch_valid, flush, epc
  );
  modport slave (
    input  stall, halt, branch_taken, branch_target, jump, jump_index, jr, reg_target, exc,
    output curAddress, pc_plus4, fetch_valid, flush, epc
  );
`else
  modport master (
    output stall, halt, branch_taken, branch_target, jump, jump_index, jr, reg_target,
    input  curAddress, pc_plus4, fetch_valid, flush
  );
  modport slave (
    input  stall, halt, branch_taken, branch_target, jump, jump_index, jr, reg_target,
    output curAddress, pc_plus4, fetch_valid, flush
  );
`endif
endinterface

// File: rtl/pc_controller.sv
// Fetch-address sequencer: hold/increment/redirect with a one-cycle flush bubble and a sticky halt.
// `PC_CTRL_EXC_EN enables the exception path (exc input, epc register, misaligned-jr trap).
module pc_controller #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic            clk,
  input  logic            reset,
  pc_controller_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_plus4;

  assign pc_plus4        = addr_q + 32'd4;
  assign bus.curAddress  = addr_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.flush       = (state_q == FLUSH);

`ifdef PC_CTRL_EXC_EN
  logic [31:0] epc_q, epc_d;
  logic        unused_bits;

  assign bus.epc     = epc_q;
  assign unused_bits = ^bus.branch_target[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) epc_q <= 32'h0;
    else        epc_q <= epc_d;
  end
`else
  logic unused_bits;

  // Target alignment discards these bits; the vector only matters with exceptions built in.
  assign unused_bits = ^{bus.branch_target[1:0], bus.reg_target[1:0], EXC_VECTOR};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      addr_q  <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef PC_CTRL_EXC_EN
    epc_d   = epc_q;
`endif
    case (state_q)
      BOOT:  state_d = RUN;
      RUN: begin
`ifdef PC_CTRL_EXC_EN
        if (bus.exc) begin
          epc_d   = addr_q;
          addr_d  = EXC_VECTOR;
          state_d = FLUSH;
        end else
`endif
        if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.stall) begin
          state_d = RUN;
        end else if (bus.jr) begin
          state_d = FLUSH;
`ifdef PC_CTRL_EXC_EN
          // A misaligned register target traps instead of being silently aligned.
          if (bus.reg_target[1:0] != 2'b00) begin
            epc_d  = addr_q;
            addr_d = EXC_VECTOR;
          end else begin
            addr_d = bus.reg_target;
          end
`else
          addr_d = {bus.reg_target[31:2], 2'b00};
`endif
        end else if (bus.jump) begin
          addr_d  = {pc_plus4[31:28], bus.jump_index, 2'b00};
          state_d = FLUSH;
        end else if (bus.branch_taken) begin
          addr_d  = {bus.branch_target[31:2], 2'b00};
          state_d = FLUSH;
        end else begin
          addr_d  = pc_plus4;
        end
      end
      FLUSH:   state_d = RUN;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_controller.sv
// Directed bench for pc_controller; optional exception vectors run when PC_CTRL_EXC_EN is defined.
module tb_pc_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pc_controller_if bus ();

  pc_controller #(
    .RESET_ADDR(32'h0000_0000),
    .EXC_VECTOR(32'h8000_0180)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] addr, input logic fv, input logic fl);
    check({tag, ".addr"},  bus.curAddress,  addr);
    check({tag, ".fv"},    {31'b0, bus.fetch_valid}, {31'b0, fv});
    check({tag, ".flush"}, {31'b0, bus.flush},       {31'b0, fl});
  endtask

  task automatic idle();
    bus.stall         = 1'b0;
    bus.halt          = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_index    = 26'h0;
    bus.jr            = 1'b0;
    bus.reg_target    = 32'h0;
`ifdef PC_CTRL_EXC_EN
    bus.exc           = 1'b0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(negedge clk);
    chk_state("reset", 32'h0, 1'b0, 1'b0);
`ifdef PC_CTRL_EXC_EN
    check("reset.epc", bus.epc, 32'h0);
`endif
    reset = 1'b1;
    // BOOT: still not fetching
    step();
    chk_state("boot_exit", 32'h0, 1'b1, 1'b0);
    check("pc_plus4_0", bus.pc_plus4, 32'h4);
    step(); chk_state("inc4",  32'h4, 1'b1, 1'b0);
    step(); chk_state("inc8",  32'h8, 1'b1, 1'b0);
    step(); chk_state("inc12", 32'hC, 1'b1, 1'b0);
    step(); chk_state("inc16", 32'h10, 1'b1, 1'b0);

    // Branch with low bits set; target aligned
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0103;
    step(); chk_state("br_flush", 32'h100, 1'b0, 1'b1);
    // Requests during FLUSH are ignored
    idle();
    bus.jump       = 1'b1;
    bus.jump_index = 26'h3FF_FFFF;
    step(); chk_state("br_run", 32'h100, 1'b1, 1'b0);
    idle();
    step(); chk_state("br_inc", 32'h104, 1'b1, 1'b0);

    // Jump to 0x4000_0008 via jr, then J
    bus.jr = 1'b1; bus.reg_target = 32'h4000_0008;
    step(); chk_state("jr_flush", 32'h4000_0008, 1'b0, 1'b1);
    idle();
    step(); chk_state("jr_run", 32'h4000_0008, 1'b1, 1'b0);
    bus.jump = 1'b1; bus.jump_index = 26'h000_0040;
    step(); chk_state("j_flush", 32'h4000_0100, 1'b0, 1'b1);
    idle();
    step(); chk_state("j_run", 32'h4000_0100, 1'b1, 1'b0);

    // Stall beats jr
    bus.stall = 1'b1; bus.jr = 1'b1; bus.reg_target = 32'h0000_2000;
    step(); chk_state("stall1", 32'h4000_0100, 1'b1, 1'b0);
    step(); chk_state("stall2", 32'h4000_0100, 1'b1, 1'b0);
    bus.stall = 1'b0;
    step(); chk_state("unstall_jr", 32'h2000, 1'b0, 1'b1);
    idle();
    step(); chk_state("unstall_run", 32'h2000, 1'b1, 1'b0);

    // Jump outranks branch
    bus.jump = 1'b1; bus.jump_index = 26'h000_0100;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_7000;
    step(); chk_state("j_over_br", 32'h0000_0400, 1'b0, 1'b1);
    idle();
    step();

`ifndef PC_CTRL_EXC_EN
    bus.jr = 1'b1; bus.reg_target = 32'h0000_3003;
    step(); chk_state("jr_misalign", 32'h3000, 1'b0, 1'b1);
    idle();
    step();
`endif

    // Wrap
    bus.jr = 1'b1; bus.reg_target = 32'hFFFF_FFFC;
    step(); chk_state("wrap_flush", 32'hFFFF_FFFC, 1'b0, 1'b1);
    idle();
    step(); chk_state("wrap_run", 32'hFFFF_FFFC, 1'b1, 1'b0);
    check("wrap_pc4", bus.pc_plus4, 32'h0);
    step(); chk_state("wrap_zero", 32'h0, 1'b1, 1'b0);

    // Halt is absorbing
    bus.halt = 1'b1;
    step(); chk_state("halt0", 32'h0, 1'b0, 1'b0);
    idle();
    bus.jr = 1'b1; bus.reg_target = 32'h0000_5000;
    for (int i = 0; i < 5; i++) begin
      step(); chk_state($sformatf("halt%0d", i + 1), 32'h0, 1'b0, 1'b0);
    end
    idle();

    // Reset in FLUSH
    reset = 1'b0; #1;
    chk_state("rst_halt", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(); step(); step();
    chk_state("rerun", 32'h8, 1'b1, 1'b0);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0200;
    step(); chk_state("pre_rst_flush", 32'h200, 1'b0, 1'b1);
    idle();
    reset = 1'b0; #1;
    chk_state("rst_in_flush", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();

`ifdef PC_CTRL_EXC_EN
    bus.jr = 1'b1; bus.reg_target = 32'h0000_0020;
    step(); idle(); step();
    chk_state("exc_at20", 32'h20, 1'b1, 1'b0);
    bus.exc = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0400;
    step(); chk_state("exc_flush", 32'h8000_0180, 1'b0, 1'b1);
    check("exc_epc", bus.epc, 32'h20);
    // exc in FLUSH ignored
    bus.branch_taken = 1'b0;
    step(); chk_state("exc_run", 32'h8000_0180, 1'b1, 1'b0);
    check("exc_epc_hold", bus.epc, 32'h20);
    idle();
    step(); chk_state("exc_inc", 32'h8000_0184, 1'b1, 1'b0);
    bus.jr = 1'b1; bus.reg_target = 32'h0000_0102;
    step(); chk_state("jr_trap", 32'h8000_0180, 1'b0, 1'b1);
    check("jr_trap_epc", bus.epc, 32'h8000_0184);
    idle();
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_controller.md
# pc_controller

Sequencing controller for the `program_counter` datapath of the MIPS CPU. It owns the 32-bit fetch address `curAddress` and decides each cycle whether to hold it, increment it, or redirect it to a branch, jump, jump-register or exception target. Redirects produce a one-cycle fetch bubble and flush pulse for the fetch/decode stages, and a halt state freezes fetch until reset.

## Interface
- `RESET_ADDR`, default 32'h0000_0000, fetch address loaded on reset.
- `EXC_VECTOR`, default 32'h8000_0180, exception handler address; used only with `PC_CTRL_EXC_EN`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the current fetch address.
- `halt`  in  1  enter HALTED.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  J/JAL redirect.
- `jump_index`  in  26  instruction index field.
- `jr`  in  1  JR/JALR redirect.
- `reg_target`  in  32  register-sourced destination.
- `exc`  in  1  exception request; exists only with `PC_CTRL_EXC_EN`.
- `curAddress`  out  32  current fetch address.
- `pc_plus4`  out  32  `curAddress + 4`, combinational, mod 2^32.
- `fetch_valid`  out  1  high only in RUN.
- `flush`  out  1  high only in FLUSH.
- `epc`  out  32  faulting address; exists only with `PC_CTRL_EXC_EN`.

## Operation
- States: BOOT, RUN, FLUSH, HALTED. 2-bit registered state.
- Reset values: state=BOOT, `curAddress`=RESET_ADDR, `epc`=0. Outputs follow from these: `fetch_valid`=0, `flush`=0.
- BOOT: unconditionally go to RUN next cycle. Ignore all inputs. Hold `curAddress`.
- RUN, with priority from highest to lowest:
  - exc: `epc`<=`curAddress`, `curAddress`<=EXC_VECTOR, go to FLUSH.
  - halt: hold the address, go to HALTED.
  - stall: hold the address, stay in RUN.
  - jr: `curAddress`<=`reg_target`, go to FLUSH.
  - jump: `curAddress`<={`pc_plus4[31:28]`, `jump_index`, 2'b00}, go to FLUSH.
  - branch_taken: `curAddress`<={`branch_target[31:2]`, 2'b00}, go to FLUSH.
  - otherwise: `curAddress`<=`pc_plus4`. The address wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- Misaligned jr (`reg_target[1:0]`!=0):
  - With EXC_EN: treated as an exception. `epc`<=`curAddress`, vector to EXC_VECTOR.
  - Without EXC_EN: low two bits are cleared.
- FLUSH: lasts one cycle and always returns to RUN. Hold `curAddress`. Ignore stall, halt, jr, jump and branch; `exc` in FLUSH is also ignored.
- HALTED: absorbing state. Only `reset` exits it. Hold `curAddress`.
- `reset` asserted in any state, including mid-FLUSH, returns immediately to the reset values.

## Timing
- Sequential increment: decision in RUN at cycle N, new address visible after edge N+1. One fetch per cycle.
- Redirect at cycle N:
  - Cycle N+1: `curAddress`=target, `flush`=1, `fetch_valid`=0.
  - Cycle N+2: RUN, target fetched with `fetch_valid`=1.
  - Penalty is exactly one bubble.
- Stall: zero-latency hold. `fetch_valid` stays 1, so consumers must qualify with their own stall.
- First valid fetch: the second rising edge after `reset` deasserts. BOOT lasts one cycle.
- Simultaneous requests resolve by the RUN priority list. `pc_plus4` is combinational from the `curAddress` register.

## Configuration
- `PC_CTRL_EXC_EN` defined:
  - `exc` input and `epc` output exist.
  - The exception branch is active, including the misaligned-jr trap.
- `PC_CTRL_EXC_EN` undefined:
  - Ports `exc`/`epc` and the `epc` register are removed.
  - Priority starts at halt.
  - Misaligned jr targets are aligned by clearing bits [1:0].
  - EXC_VECTOR is unused.

## Test plan
- Reset release then 4 free-running cycles:
  - Edge 1 after release: `curAddress`=0, `fetch_valid` goes 0→1.
  - Following edges: `curAddress` steps 4, 8, 12.
- `branch_taken`=1, `branch_target`=32'h0000_0103 while at 32'h10:
  - Next cycle: `curAddress`=32'h100, `flush`=1, `fetch_valid`=0.
  - Cycle after: RUN at 32'h100.
- `jump`=1, `jump_index`=26'h000_0040 at `curAddress` 32'h4000_0008 → `curAddress`=32'h4000_0100.
- `stall`=1 and `jr`=1 in the same cycle → address held, no flush. Release stall with jr still high → redirect to `reg_target`.
- Wrap case: force 32'hFFFF_FFFC via jr, then increment → 32'h0000_0000. Assert `halt` → address frozen 5 cycles with `fetch_valid`=0. Pulse `reset` low → back to RESET_ADDR.
- With `PC_CTRL_EXC_EN`:
  - `exc` and `branch_taken` together at 32'h20 → `curAddress`=32'h8000_0180, `epc`=32'h20.
  - `jr` to 32'h0000_0102 → vectors to 32'h8000_0180.
